// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, fetch states and reset vector
package instruction_fetch_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;
    localparam int RESET_VECTOR = 0;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
endpackage

// File: rtl/instruction_fetch_program_counter.sv
// program_counter: fetch address register with load, increment, hold and natural wrap
module program_counter
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk)
        pc <= reset ? ADDR_W'(RESET_VECTOR) : load ? load_addr : inc ? pc + ADDR_W'(1) : pc;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM and instruction register feeding decode from a combinational ROM
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);
    state_t state, state_n;
    logic jump, capture;
    logic [ADDR_W-1:0] pc;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk(clk),
        .reset(reset),
        .load(jump),
        .load_addr(jump_addr),
        .inc(capture),
        .pc(pc)
    );

    assign rom_addr = pc;

    always_ff @(posedge clk)
        state <= reset ? BOOT : state_n;

    // halt alone decides the destination of every state, including a jump+halt
    always_comb begin
        state_n = halt ? HALTED : RUN;
        jump = jump_en && state != BOOT;
        capture = state == RUN && !jump_en && !halt && (!instr_valid || instr_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (jump) begin
            instr_valid <= 1'b0;
        end else if (capture) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed-step bench with ROM[i] = 16'hA000 + i
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        jump_en;
    logic [14:0] jump_addr;
    logic        halt;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign rom_data = 16'hA000 + {1'b0, rom_addr};

    instruction_fetch dut (
        .clk(clk),
        .reset(reset),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .jump_en(jump_en),
        .jump_addr(jump_addr),
        .halt(halt),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [15:0] e_instr, input logic [14:0] e_pc);
        chk({tag, " valid"}, 32'(instr_valid), 32'd1);
        chk({tag, " instr"}, 32'(instr), 32'(e_instr));
        chk({tag, " instr_pc"}, 32'(instr_pc), 32'(e_pc));
    endtask

    initial begin
        reset = 1'b1; jump_en = 1'b0; jump_addr = '0; halt = 1'b0; instr_ready = 1'b1;
        step(); step();
        chk("rst valid", 32'(instr_valid), 32'd0);
        chk("rst instr", 32'(instr), 32'd0);
        chk("rst instr_pc", 32'(instr_pc), 32'd0);
        chk("rst rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        step();
        chk("boot valid", 32'(instr_valid), 32'd0);
        chk("boot rom_addr", 32'(rom_addr), 32'd0);
        step(); chk_instr("seq0", 16'hA000, 15'd0);
        step(); chk_instr("seq1", 16'hA001, 15'd1);
        step(); chk_instr("seq2", 16'hA002, 15'd2);
        step(); step(); step(); chk_instr("seq5", 16'hA005, 15'd5);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_instr("stall", 16'hA005, 15'd5);
            chk("stall rom_addr", 32'(rom_addr), 32'd6);
        end
        instr_ready = 1'b1;
        step(); chk_instr("unstall", 16'hA006, 15'd6);
        instr_ready = 1'b0;
        step(); chk_instr("prejump stall", 16'hA006, 15'd6);
        jump_en = 1'b1; jump_addr = 15'h0100;
        step();
        chk("jump bubble valid", 32'(instr_valid), 32'd0);
        chk("jump rom_addr", 32'(rom_addr), 32'h100);
        jump_en = 1'b0; instr_ready = 1'b1;
        step(); chk_instr("jump target", 16'hA100, 15'h0100);
        jump_en = 1'b1; jump_addr = 15'h7FFE;
        step(); chk("wrapjump valid", 32'(instr_valid), 32'd0);
        jump_en = 1'b0;
        step(); chk_instr("wrap 7FFE", 16'h1FFE, 15'h7FFE);
        step(); chk_instr("wrap 7FFF", 16'h1FFF, 15'h7FFF);
        step(); chk_instr("wrap 0000", 16'hA000, 15'h0000);
        step(); chk_instr("wrap 0001", 16'hA001, 15'h0001);
        jump_en = 1'b1; jump_addr = 15'd9;
        step(); jump_en = 1'b0;
        step(); chk_instr("prehalt", 16'hA009, 15'd9);
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt valid", 32'(instr_valid), 32'd0);
            chk("halt rom_addr", 32'(rom_addr), 32'd10);
        end
        halt = 1'b0;
        step(); chk("resume bubble", 32'(instr_valid), 32'd0);
        step(); chk_instr("resume", 16'hA00A, 15'd10);
        jump_en = 1'b1; halt = 1'b1; jump_addr = 15'h0030;
        step();
        chk("jumphalt valid", 32'(instr_valid), 32'd0);
        chk("jumphalt rom_addr", 32'(rom_addr), 32'h30);
        jump_en = 1'b0; halt = 1'b0;
        step(); chk("jumphalt resume bubble", 32'(instr_valid), 32'd0);
        step(); chk_instr("jumphalt target", 16'hA030, 15'h0030);
        jump_en = 1'b1; jump_addr = 15'd20;
        step(); jump_en = 1'b0;
        step(); chk_instr("prestall20", 16'hA014, 15'd20);
        instr_ready = 1'b0;
        step(); chk_instr("stall20", 16'hA014, 15'd20);
        reset = 1'b1;
        step();
        chk("midrst valid", 32'(instr_valid), 32'd0);
        chk("midrst instr", 32'(instr), 32'd0);
        chk("midrst instr_pc", 32'(instr_pc), 32'd0);
        chk("midrst rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0; instr_ready = 1'b1;
        step(); chk("restart boot", 32'(instr_valid), 32'd0);
        step(); chk_instr("restart", 16'hA000, 15'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
